mac_result_writer: RTL and testbench
====================================

# mac_result_writer

Downstream stage of the SpMV multiply-accumulate unit (`mac`). Captures each finished row sum that `mac` emits on `push_out`/`v_out` (no backpressure available), buffers it in a FIFO and issues one 64-bit memory write per result to consecutive 8-byte addresses from a programmed base. Completion is signalled once the programmed number of results has been written.

## Interface
- `FIFO_DEPTH`, 64, result buffer entries; power of two, at least 4.
- `LOG2_FIFO_DEPTH`, log2(FIFO_DEPTH), pointer width; derived, not overridden.
- `ADDR_WIDTH`, 48, memory byte-address width.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that latches the job; honoured only in IDLE.
- `base_addr`  in  ADDR_WIDTH  byte address of result 0; 8-byte aligned; latched on `start`.
- `row_count`  in  32  number of results expected; latched on `start`.
- `push_in`  in  1  result valid from `mac` (`push_out`).
- `v_in`  in  64  result value from `mac` (`v_out`).
- `mem_req`  out  1  write request valid.
- `mem_addr`  out  ADDR_WIDTH  write byte address.
- `mem_data`  out  64  write data.
- `mem_stall`  in  1  memory not accepting; a transfer occurs on a cycle with `mem_req && !mem_stall`.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse on job completion.
- `err`  out  2  sticky flags: [0] FIFO overflow (result dropped), [1] push while IDLE.

## Operation
- Reset values: `mem_req`=0, `mem_addr`=0, `mem_data`=0, `busy`=0, `done`=0, `err`=0. FIFO empty, counters 0, state IDLE.
- States: IDLE, RUN, DONE.
- IDLE to RUN on `start` when `row_count`≠0: latch `base_addr` and `row_count`, clear `err` and the write counter. The FIFO is not flushed.
- IDLE to DONE on `start` when `row_count`=0.
- RUN to DONE on the cycle in which the transfer of the result at index `row_count`−1 completes.
- DONE to IDLE unconditionally after one cycle; `done`=1 only while in DONE.
- `start` outside IDLE is ignored.
- Push accept rule:
  - In RUN or DONE, `push_in` writes `v_in` into the FIFO unless the FIFO is full and not popping in that cycle.
  - A push with simultaneous pop on a full FIFO is accepted.
  - A rejected push sets `err[0]`; the data is lost.
- A push in IDLE is dropped and sets `err[1]`.
- Output register:
  - `mem_req/mem_addr/mem_data` form a single registered stage.
  - The stage loads from the FIFO head when it is empty, or when it is transferring that cycle, and the FIFO is non-empty in RUN.
  - While `mem_req`=1 and `mem_stall`=1, all three outputs hold stable.
- Address: `mem_addr` = `base_addr` + 8·idx, where idx is a 32-bit result index. The addition is modulo 2^ADDR_WIDTH, and wrap is not flagged.
- No more than `row_count` requests are issued per job. Surplus FIFO entries remain for the next job.
- Reset mid-job: all state is cleared immediately and an in-flight `mem_req` drops asynchronously.

## Timing
- `push_in` at edge N with FIFO and output stage empty in RUN: `mem_req`=1 after edge N+1 (2-cycle latency).
- Sustained throughput is 1 result per cycle with `mem_stall`=0.
- `done` is asserted the cycle after the final transfer. `busy` falls in the same cycle.
- `err` bits update on the edge following the offending push.

## Configuration
- `MAC_RESULT_WRITER_STALL_CNT_EN` defined:
  - Adds output port `stall_cycles` (32 bits, reset 0, cleared on accepted `start`).
  - It counts cycles with `mem_req && mem_stall`, saturating at 2^32−1.
- Undefined: the port and counter do not exist; all other behaviour is identical.

## Test plan
- Basic job:
  - Stimulus: reset, `start` with base 0x1000, count 4; push 1.0, 2.0, 3.0, 4.0 (0x3FF0…, 0x4000…, 0x4008…, 0x4010…) on consecutive cycles with no stall.
  - Response: writes to 0x1000, 0x1008, 0x1010, 0x1018 in order, first `mem_req` 2 cycles after the first push, then `done` pulse, `err`=0.
- Stall hold:
  - Stimulus: as above with `mem_stall` high for cycles 3–7.
  - Response: `mem_addr`/`mem_data` stable throughout the stall, no duplicates or losses; `stall_cycles`=5 when the macro is defined.
- Overflow:
  - Stimulus: FIFO_DEPTH=4, count 8, `mem_stall` held high, 6 pushes (values 1..6).
  - Response: one value in the output stage plus 4 in the FIFO, the 6th dropped, `err[0]`=1.
  - After release: 5 writes of values 1..5, no `done`.
- Zero count:
  - Stimulus: `start` with count 0.
  - Response: `done` one cycle later, `mem_req` never asserted.
- Stray and reset:
  - Stimulus: push 0xDEAD in IDLE; separately, assert `rst_n`=0 mid-job while `mem_req`=1.
  - Response: `err[1]`=1 with no write for the stray push; on reset, `mem_req` drops at once and all outputs return to reset values.

Source files
------------

// File: rtl/mac_result_writer.sv
// mac_result_writer: buffers mac row sums in a FIFO and writes them as 64-bit stores to base+8*idx; 2-cycle push-to-req, 1/cycle, holds on mem_stall.
// No upstream backpressure (full FIFO drops and flags err[0]); `MAC_RESULT_WRITER_STALL_CNT_EN adds the stall_cycles port.

// fifo: generic synchronous FIFO with combinational head; 1-cycle push-to-visible.
// Caller must only push when !full (or full with pop) and only pop when !empty.
module fifo #(
  parameter int WIDTH      = 64,
  parameter int DEPTH      = 64,
  parameter int LOG2_DEPTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0]      mem [DEPTH];
  logic [LOG2_DEPTH-1:0] wr_ptr;
  logic [LOG2_DEPTH-1:0] rd_ptr;
  logic [LOG2_DEPTH:0]   count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + LOG2_DEPTH'(1);
      if (pop)  rd_ptr <= rd_ptr + LOG2_DEPTH'(1);
      case ({push, pop})
        2'b10:   count <= count + (LOG2_DEPTH+1)'(1);
        2'b01:   count <= count - (LOG2_DEPTH+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; only entries behind valid pointers are ever read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign pop_dat = mem[rd_ptr];
  assign full    = (count == (LOG2_DEPTH+1)'(DEPTH));
  assign empty   = (count == '0);
endmodule

module mac_result_writer #(
  parameter int FIFO_DEPTH      = 64,
  parameter int LOG2_FIFO_DEPTH = $clog2(FIFO_DEPTH),
  parameter int ADDR_WIDTH      = 48
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [31:0]           row_count,
  input  logic                  push_in,
  input  logic [63:0]           v_in,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [63:0]           mem_data,
  input  logic                  mem_stall,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            err
`ifdef MAC_RESULT_WRITER_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [31:0]           rows_q;
  logic [31:0]           issue_idx;
  logic [31:0]           xfer_cnt;
  logic [ADDR_WIDTH-1:0] addr_off;
  logic [63:0]           fifo_dat;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;
  logic                  push_acc;
  logic                  xfer;
  logic                  last_xfer;
  logic                  start_acc;
  logic                  start_run;
  logic [1:0]            err_set;

  assign start_acc = (state == IDLE) && start;
  assign start_run = start_acc && (row_count != 32'd0);
  assign xfer      = mem_req && !mem_stall;
  assign last_xfer = xfer && (xfer_cnt == rows_q - 32'd1);

  // The output stage refills from the head whenever it is empty or draining,
  // but never beyond row_count issues so surplus entries wait for the next job.
  assign fifo_pop = (state == RUN) && !fifo_empty && (issue_idx < rows_q) &&
                    (!mem_req || !mem_stall);
  assign push_acc = push_in && (state != IDLE) && (!fifo_full || fifo_pop);
  assign err_set  = {push_in && (state == IDLE),
                     push_in && (state != IDLE) && !push_acc};
  assign addr_off = ADDR_WIDTH'({issue_idx, 3'b000});

  fifo #(
    .WIDTH      (64),
    .DEPTH      (FIFO_DEPTH),
    .LOG2_DEPTH (LOG2_FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_acc),
    .push_dat (v_in),
    .pop      (fifo_pop),
    .pop_dat  (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (row_count != 32'd0) ? RUN : DONE;
      RUN:     if (last_xfer) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q    <= '0;
      rows_q    <= '0;
      issue_idx <= '0;
      xfer_cnt  <= '0;
    end else if (start_acc) begin
      base_q    <= base_addr;
      rows_q    <= row_count;
      issue_idx <= '0;
      xfer_cnt  <= '0;
    end else begin
      if (fifo_pop) issue_idx <= issue_idx + 32'd1;
      if (xfer)     xfer_cnt  <= xfer_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req  <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
    end else if (fifo_pop) begin
      mem_req  <= 1'b1;
      mem_addr <= base_q + addr_off;
      mem_data <= fifo_dat;
    end else if (xfer) begin
      mem_req  <= 1'b0;
    end
  end

  // A flag raised in the same cycle as a job start survives the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 2'b00;
    else        err <= (start_run ? 2'b00 : err) | err_set;
  end

`ifdef MAC_RESULT_WRITER_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cycles <= '0;
    else if (start_acc)
      stall_cycles <= '0;
    else if (mem_req && mem_stall && (stall_cycles != 32'hFFFF_FFFF))
      stall_cycles <= stall_cycles + 32'd1;
  end
`endif
endmodule

// File: tb/tb_mac_result_writer.sv
// Directed bench for mac_result_writer (FIFO_DEPTH=4): basic job, stall hold, overflow, zero count, stray push, async reset, address wrap.
module tb_mac_result_writer;
  localparam int AW = 48;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [31:0]   row_count = '0;
  logic          push_in = 1'b0;
  logic [63:0]   v_in = '0;
  logic          mem_stall = 1'b0;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [63:0]   mem_data;
  logic          busy;
  logic          done;
  logic [1:0]    err;
`ifdef MAC_RESULT_WRITER_STALL_CNT_EN
  logic [31:0]   stall_cycles;
`endif

  int          vec_cnt = 0;
  int          err_cnt = 0;
  int          done_cnt = 0;
  bit          req_seen = 1'b0;
  logic [63:0] log_addr[$];
  logic [63:0] log_data[$];
  logic [63:0] exp_data[$];
  logic        hold_vld = 1'b0;
  logic [AW-1:0] hold_addr = '0;
  logic [63:0] hold_data = '0;

  mac_result_writer #(.FIFO_DEPTH(4), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .row_count (row_count),
    .push_in   (push_in),
    .v_in      (v_in),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_stall (mem_stall),
    .busy      (busy),
    .done      (done),
    .err       (err)
`ifdef MAC_RESULT_WRITER_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 30; i++) begin
      if (done) break;
      step();
    end
    check({tag, "_done"}, done, 1);
  endtask

  task automatic check_log(input string tag, input logic [AW-1:0] base, input int first);
    logic [AW-1:0] ea;
    check({tag, "_count"}, 64'(log_addr.size()), 64'(exp_data.size()));
    for (int i = 0; i < exp_data.size() && i < log_addr.size(); i++) begin
      ea = base + AW'((first + i) * 8);
      check($sformatf("%s_addr%0d", tag, i), log_addr[i], 64'(ea));
      check($sformatf("%s_data%0d", tag, i), log_data[i], exp_data[i]);
    end
    log_addr.delete();
    log_data.delete();
    exp_data.delete();
  endtask

  // Transfer log and stall-hold watcher, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (hold_vld) begin
          check("hold_req", mem_req, 1);
          check("hold_addr", mem_addr, hold_addr);
          check("hold_data", mem_data, hold_data);
        end
        hold_vld  = mem_req && mem_stall;
        hold_addr = mem_addr;
        hold_data = mem_data;
        if (mem_req && !mem_stall) begin
          log_addr.push_back(64'(mem_addr));
          log_data.push_back(mem_data);
        end
        if (mem_req) req_seen = 1'b1;
        if (done) done_cnt++;
      end else begin
        hold_vld = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] fp[4];
    logic [63:0] sv[4];
    fp = '{64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000,
           64'h4008_0000_0000_0000, 64'h4010_0000_0000_0000};
    sv = '{64'hA000_0000_0000_0001, 64'hB000_0000_0000_0002,
           64'hC000_0000_0000_0003, 64'hD000_0000_0000_0004};

    repeat (3) step();
    rst_n = 1'b1;
    step();
    check("rst_req", mem_req, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_data", mem_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);

    // Basic job: four pushes back to back, no stall.
    start = 1'b1; base_addr = 48'h1000; row_count = 4;
    step();
    start = 1'b0;
    check("basic_busy", busy, 1);
    push_in = 1'b1; v_in = fp[0];
    step();
    check("lat_early", mem_req, 0);
    v_in = fp[1];
    step();
    check("lat_req", mem_req, 1);
    check("lat_addr", mem_addr, 48'h1000);
    check("lat_data", mem_data, fp[0]);
    v_in = fp[2];
    step();
    v_in = fp[3];
    step();
    push_in = 1'b0;
    wait_done("basic");
    check("basic_busy_fall", busy, 0);
    step();
    check("basic_done_pulse", done, 0);
    check("basic_err", err, 0);
    check("basic_done_cnt", done_cnt, 1);
    for (int i = 0; i < 4; i++) exp_data.push_back(fp[i]);
    check_log("basic", 48'h1000, 0);

    // Stall held high for loop cycles 3..7.
    start = 1'b1; base_addr = 48'h2000; row_count = 4;
    step();
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      push_in   = (k < 4);
      v_in      = (k < 4) ? sv[k] : 64'h0;
      mem_stall = (k >= 3 && k <= 7);
      step();
    end
    push_in = 1'b0; mem_stall = 1'b0;
    wait_done("stall");
    step();
`ifdef MAC_RESULT_WRITER_STALL_CNT_EN
    check("stall_cycles", stall_cycles, 5);
`endif
    check("stall_err", err, 0);
    check("stall_done_cnt", done_cnt, 2);
    for (int i = 0; i < 4; i++) exp_data.push_back(sv[i]);
    check_log("stall", 48'h2000, 0);

    // Overflow: depth 4, memory stalled, six pushes.
    start = 1'b1; base_addr = 48'h3000; row_count = 8; mem_stall = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      push_in = 1'b1; v_in = 64'(k + 1);
      step();
    end
    push_in = 1'b0;
    step();
    check("ovf_err", err, 2'b01);
    check("ovf_req", mem_req, 1);
    check("ovf_stage", mem_data, 1);
    mem_stall = 1'b0;
    repeat (10) step();
    check("ovf_nodone", done_cnt, 2);
    check("ovf_busy", busy, 1);
    for (int i = 1; i <= 5; i++) exp_data.push_back(64'(i));
    check_log("ovf", 48'h3000, 0);
    for (int k = 0; k < 3; k++) begin
      push_in = 1'b1; v_in = 64'((k + 7) * 16);
      step();
    end
    push_in = 1'b0;
    wait_done("ovf_tail");
    step();
    exp_data.push_back(64'h70); exp_data.push_back(64'h80); exp_data.push_back(64'h90);
    check_log("ovf_tail", 48'h3000, 5);

    // Zero count completes immediately.
    req_seen = 1'b0;
    start = 1'b1; base_addr = 48'h5000; row_count = 0;
    step();
    start = 1'b0;
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    step();
    check("zero_done_pulse", done, 0);
    repeat (3) step();
    check("zero_noreq", req_seen, 0);

    // Stray push while idle.
    push_in = 1'b1; v_in = 64'hDEAD;
    step();
    push_in = 1'b0;
    check("stray_err1", err[1], 1);
    repeat (3) step();
    check("stray_nowrite", 64'(log_addr.size()), 0);
    check("stray_noreq", req_seen, 0);

    // Reset while a request is pending under stall.
    start = 1'b1; base_addr = 48'h4000; row_count = 2; mem_stall = 1'b1;
    step();
    start = 1'b0;
    push_in = 1'b1; v_in = 64'h55;
    step();
    push_in = 1'b0;
    step();
    check("rst_pre_req", mem_req, 1);
    check("run_err_clr", err, 0);
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_req", mem_req, 0);
    check("rst_async_addr", mem_addr, 0);
    check("rst_async_data", mem_data, 0);
    check("rst_async_busy", busy, 0);
    check("rst_async_err", err, 0);
    step();
    step();
    rst_n = 1'b1; mem_stall = 1'b0;
    repeat (5) step();
    check("rst_nowrite", 64'(log_addr.size()), 0);
    check("rst_idle_req", mem_req, 0);

    // Address wraps modulo 2^48 without a flag.
    start = 1'b1; base_addr = 48'hFFFF_FFFF_FFF8; row_count = 2;
    step();
    start = 1'b0;
    push_in = 1'b1; v_in = 64'h1111;
    step();
    v_in = 64'h2222;
    step();
    push_in = 1'b0;
    wait_done("wrap");
    step();
    check("wrap_err", err, 0);
    exp_data.push_back(64'h1111); exp_data.push_back(64'h2222);
    check_log("wrap", 48'hFFFF_FFFF_FFF8, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
